// File: rtl/pong_pixel_gen.sv
`default_nettype none
// ============================================================================
// Module      : pong_pixel_gen
// Description : Pong game-state and pixel-colour stage fed by a 640x480 VGA
//               timing generator. Ball, paddle and serve state advance once
//               per frame, during vertical blanking (row 481). The colour of
//               each pixel is registered with one clock of latency.
//
// Ports       : clk_100MHz  - system clock
//               reset       - synchronous, active-high reset
//               p_tick      - 25 MHz pixel tick (1-clock pulse)
//               video_on    - high inside the visible 640x480 area
//               x, y        - current pixel column / row
//               btn_up      - paddle up (level, already debounced)
//               btn_down    - paddle down (level, already debounced)
//               rgb         - registered {R,G,B} 4 bits each
//               frame_tick  - 1-clock pulse, once per frame
//               in_play     - high while the ball is in play
//               miss_cnt    - misses since reset
//
// Options     : PONG_MISS_CNT_EN - when defined, miss_cnt is a saturating
//               4-bit counter; otherwise miss_cnt is tied to zero.
//
// Revision    : 1.0 - initial release
// ============================================================================
module pong_pixel_gen #(
    parameter int BALL_V       = 2,
    parameter int PAD_V        = 3,
    parameter int SERVE_FRAMES = 60
) (
    input  logic        clk_100MHz,
    input  logic        reset,
    input  logic        p_tick,
    input  logic        video_on,
    input  logic [9:0]  x,
    input  logic [9:0]  y,
    input  logic        btn_up,
    input  logic        btn_down,
    output logic [11:0] rgb,
    output logic        frame_tick,
    output logic        in_play,
    output logic [3:0]  miss_cnt
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam int              c_SCW        = $clog2(SERVE_FRAMES + 1);
    localparam logic [c_SCW-1:0] c_SERVE_LAST = c_SCW'(SERVE_FRAMES - 1);
    localparam logic [c_SCW-1:0] c_SERVE_ONE  = c_SCW'(1);

    localparam logic [9:0] c_BALL_V     = 10'(BALL_V);
    localparam logic [9:0] c_PAD_V      = 10'(PAD_V);
    localparam logic [9:0] c_PAD_MAX    = 10'd408;
    localparam logic [9:0] c_PAD_DN_LIM = 10'(408 - PAD_V);
    localparam logic [9:0] c_PAD_H_M1   = 10'd71;
    localparam logic [9:0] c_PAD_X_L    = 10'd600;
    localparam logic [9:0] c_PAD_X_R    = 10'd603;
    localparam logic [9:0] c_PAD_Y_RST  = 10'd204;
    localparam logic [9:0] c_WALL_X_L   = 10'd32;
    localparam logic [9:0] c_WALL_X_R   = 10'd39;
    localparam logic [9:0] c_WALL_HIT_X = 10'd40;
    localparam logic [9:0] c_MISS_X     = 10'd632;
    localparam logic [9:0] c_BALL_Y_BOT = 10'(472 - BALL_V);
    localparam logic [9:0] c_BALL_SZ    = 10'd8;
    localparam logic [9:0] c_BALL_SZ_M1 = 10'd7;
    localparam logic [9:0] c_SERVE_X    = 10'd316;
    localparam logic [9:0] c_SERVE_Y    = 10'd236;
    localparam logic [9:0] c_FT_X       = 10'd0;
    localparam logic [9:0] c_FT_Y       = 10'd481;

    localparam logic [11:0] c_RGB_BALL = 12'hF00;
    localparam logic [11:0] c_RGB_PAD  = 12'h0F0;
    localparam logic [11:0] c_RGB_WALL = 12'h00F;
    localparam logic [11:0] c_RGB_BG   = 12'h000;

    typedef enum logic [0:0] {
        ST_SERVE = 1'b0,
        ST_PLAY  = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t            r_state;
    logic [c_SCW-1:0]  r_serve_cnt;
    logic [9:0]        r_pad_y;
    logic [9:0]        r_ball_x;
    logic [9:0]        r_ball_y;
    // Velocity is a direction bit per axis; magnitude is always BALL_V.
    logic              r_vx_neg;
    logic              r_vy_neg;
    logic              r_frame_tick;
    logic [11:0]       r_rgb;

    // ------------------------------------------------------------------
    // Next-state combinational logic
    // ------------------------------------------------------------------
    logic [9:0] w_pad_y_next;
    logic [9:0] w_ball_r;
    logic       w_hit;
    logic       w_miss;
    logic       w_vx_neg_next;
    logic       w_vy_neg_next;
    logic [9:0] w_ball_x_next;
    logic [9:0] w_ball_y_next;

    always_comb begin
        w_pad_y_next = r_pad_y;
        if (btn_up && !btn_down) begin
            w_pad_y_next = (r_pad_y >= c_PAD_V) ? (r_pad_y - c_PAD_V) : 10'd0;
        end else if (btn_down && !btn_up) begin
            w_pad_y_next = (r_pad_y <= c_PAD_DN_LIM) ? (r_pad_y + c_PAD_V) : c_PAD_MAX;
        end
    end

    always_comb begin
        w_ball_r = r_ball_x + c_BALL_SZ_M1;
        w_hit    = (w_ball_r >= c_PAD_X_L) && (w_ball_r <= c_PAD_X_R) &&
                   ((r_ball_y + c_BALL_SZ_M1) >= r_pad_y) &&
                   (r_ball_y <= (r_pad_y + c_PAD_H_M1));
        w_miss   = (r_ball_x >= c_MISS_X);

        // All bounce checks look at the pre-update position and are
        // independent, so a top bounce and a paddle hit can share a frame.
        w_vy_neg_next = r_vy_neg;
        if (r_ball_y <= c_BALL_V) begin
            w_vy_neg_next = 1'b0;
        end
        if (r_ball_y >= c_BALL_Y_BOT) begin
            w_vy_neg_next = 1'b1;
        end

        w_vx_neg_next = r_vx_neg;
        if (r_ball_x <= c_WALL_HIT_X) begin
            w_vx_neg_next = 1'b0;
        end
        if (w_hit) begin
            w_vx_neg_next = 1'b1;
        end

        // Moves use the already-updated velocities.
        w_ball_x_next = w_vx_neg_next ? (r_ball_x - c_BALL_V) : (r_ball_x + c_BALL_V);
        w_ball_y_next = w_vy_neg_next ? (r_ball_y - c_BALL_V) : (r_ball_y + c_BALL_V);
    end

    // ------------------------------------------------------------------
    // Frame tick: one pulse per frame at the start of row 481, so that
    // every game-state change lands in vertical blanking.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            r_frame_tick <= 1'b0;
        end else begin
            r_frame_tick <= p_tick && (x == c_FT_X) && (y == c_FT_Y);
        end
    end

    // ------------------------------------------------------------------
    // Game state machine
    // ------------------------------------------------------------------
    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            r_state     <= ST_SERVE;
            r_serve_cnt <= '0;
            r_pad_y     <= c_PAD_Y_RST;
            r_ball_x    <= c_SERVE_X;
            r_ball_y    <= c_SERVE_Y;
            r_vx_neg    <= 1'b0;
            r_vy_neg    <= 1'b0;
        end else if (r_frame_tick) begin
            r_pad_y <= w_pad_y_next;
            case (r_state)
                ST_SERVE: begin
                    r_ball_x <= c_SERVE_X;
                    r_ball_y <= c_SERVE_Y;
                    if (r_serve_cnt == c_SERVE_LAST) begin
                        r_state     <= ST_PLAY;
                        r_serve_cnt <= '0;
                        r_vx_neg    <= 1'b0;
                        r_vy_neg    <= 1'b0;
                    end else begin
                        r_serve_cnt <= r_serve_cnt + c_SERVE_ONE;
                    end
                end
                ST_PLAY: begin
                    r_vx_neg <= w_vx_neg_next;
                    r_vy_neg <= w_vy_neg_next;
                    if (w_miss) begin
                        // Ball left the field: no move this frame, re-serve.
                        r_state  <= ST_SERVE;
                        r_ball_x <= c_SERVE_X;
                        r_ball_y <= c_SERVE_Y;
                    end else begin
                        r_ball_x <= w_ball_x_next;
                        r_ball_y <= w_ball_y_next;
                    end
                end
                default: begin
                    r_state <= ST_SERVE;
                end
            endcase
        end
    end

    assign in_play    = (r_state == ST_PLAY);
    assign frame_tick = r_frame_tick;

    // ------------------------------------------------------------------
    // Miss counter (optional)
    // ------------------------------------------------------------------
`ifdef PONG_MISS_CNT_EN
    logic [3:0] r_miss_cnt;

    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            r_miss_cnt <= 4'h0;
        end else if (r_frame_tick && (r_state == ST_PLAY) && w_miss &&
                     (r_miss_cnt != 4'hF)) begin
            r_miss_cnt <= r_miss_cnt + 4'h1;
        end
    end

    assign miss_cnt = r_miss_cnt;
`else
    assign miss_cnt = 4'h0;
`endif

    // ------------------------------------------------------------------
    // Pixel colour: ball > paddle > wall > background
    // ------------------------------------------------------------------
    logic       w_ball_on;
    logic       w_pad_on;
    logic       w_wall_on;
    logic [11:0] w_rgb_next;

    always_comb begin
        w_ball_on = (x >= r_ball_x) && (x < (r_ball_x + c_BALL_SZ)) &&
                    (y >= r_ball_y) && (y < (r_ball_y + c_BALL_SZ));
        w_pad_on  = (x >= c_PAD_X_L) && (x <= c_PAD_X_R) &&
                    (y >= r_pad_y) && (y <= (r_pad_y + c_PAD_H_M1));
        w_wall_on = (x >= c_WALL_X_L) && (x <= c_WALL_X_R);

        w_rgb_next = c_RGB_BG;
        if (!video_on) begin
            w_rgb_next = c_RGB_BG;
        end else if (w_ball_on) begin
            w_rgb_next = c_RGB_BALL;
        end else if (w_pad_on) begin
            w_rgb_next = c_RGB_PAD;
        end else if (w_wall_on) begin
            w_rgb_next = c_RGB_WALL;
        end
    end

    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            r_rgb <= 12'h000;
        end else begin
            r_rgb <= w_rgb_next;
        end
    end

    assign rgb = r_rgb;

endmodule
`default_nettype wire
